fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1: instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32: instruction fetch address.
REQ-006 SHALL have port imem_ready, input, 1: imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-008 SHALL have ports opcode/funct3/funct7, output, 7/3/7: instruction fields for the control unit.
REQ-009 SHALL have ports rs1/rs2/rd, output, 5 each: register indices.
REQ-010 SHALL have port imm, output, 32: sign-extended immediate.
REQ-011 SHALL have ports pc/pc_plus4, output, 32 each: current PC and PC+4 (the WB_PC source).
REQ-012 SHALL have port PCSel, input, 2: next-PC select from the control unit.
REQ-013 SHALL have port alu_result, input, 32: JALR target.
REQ-014 SHALL have port exec_stall, input, 1: hold the current instruction (data-memory busy).
REQ-015 SHALL have port instr_valid, output, 1: decoded fields valid; downstream gates regWrite/memWrite with it.
REQ-016 SHALL have ports illegal_instr/misaligned, output, 1 each: sticky fault flags.

Function
REQ-017 SHALL implement FSM with states FETCH, EXEC, HALT.
REQ-018 FETCH: imem_req=1, imem_addr=pc. On imem_ready=1, latch imem_rdata into the instruction register (IR) and go to EXEC. Otherwise stay in FETCH; no timeout.
REQ-019 EXEC: instr_valid=1 and imem_req=0.
- exec_stall=1: hold pc, IR and state.
- exec_stall=0: load next PC and return to FETCH.
- Minimum 2 cycles per instruction.
REQ-020 Next PC SHALL be:
- PC_PLUS4 -> pc+4
- PC_IMM -> pc+imm
- PC_ALU -> {alu_result[31:1],1'b0}
- any other code -> pc+4
- All arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-021 Field outputs SHALL decode combinationally from IR: opcode=IR[6:0], rd=IR[11:7], funct3=IR[14:12], rs1=IR[19:15], rs2=IR[24:20], funct7=IR[31:25].
REQ-022 imm SHALL be selected by opcode:
- I (load, op-imm, JALR): sext IR[31:20]
- S: sext {IR[31:25],IR[11:7]}
- B: sext {IR[31],IR[7],IR[30:25],IR[11:8],0}
- U (LUI/AUIPC): {IR[31:12],12'b0}
- J: sext {IR[31],IR[19:12],IR[20],IR[30:21],0}
- R and unknown: 0
REQ-023 An opcode outside {R, I-load, I-imm, JALR, S, B, LUI, AUIPC, J} in EXEC SHALL set illegal_instr, keep pc, and go to HALT instead of FETCH; exec_stall is ignored for that instruction.
REQ-024 If the computed next PC has bits[1:0]!=0 in EXEC with exec_stall=0, SHALL set misaligned, keep pc, and go to HALT.
REQ-025 HALT: imem_req=0, instr_valid=0, flags held; left only by rst.
REQ-026 imem_ready while not in FETCH SHALL be ignored; IR is unchanged.

Reset
REQ-027 rst=1 at a clock edge SHALL force, regardless of state, including mid-fetch or during a stall:
- pc=RESET_PC
- state=FETCH
- IR=32'h0000_0013 (NOP)
- illegal_instr=0, misaligned=0
REQ-028 The first cycle after reset SHALL drive imem_req=1, imem_addr=RESET_PC, instr_valid=0.

Structure
REQ-029 Opcode constants (Rtype, ItypeLd, ItypeImm, ItypeJALR, Stype, Btype, UtypeLUI, UtypeAUIPC, Jtype) SHALL come from shared package InstrTypes.
REQ-030 PC_PLUS4/PC_ALU/PC_IMM codes SHALL come from shared package Instructions; the FSM state enum SHALL be local.
REQ-031 Immediate extraction SHALL be the combinational sub-module imm_gen (in: instr[31:0]; out: imm[31:0]).

Verification
REQ-032 Reset, then imem_ready after 3 wait cycles with rdata=32'h00500093 (addi x1,x0,5) -> EXEC with opcode=7'h13, rd=1, imm=5; PCSel=PC_PLUS4 -> next fetch at 32'h4.
REQ-033 At pc=32'h100, rdata=32'hFE000EE3 (beq, offset -4), PCSel=PC_IMM -> next imem_addr=32'hFC.
REQ-034 In EXEC with exec_stall=1 for 4 cycles -> pc, fields and instr_valid steady; fetch of pc+4 starts the cycle after exec_stall falls.
REQ-035 JALR with alu_result=32'h203, PCSel=PC_ALU -> next pc=32'h202 -> misaligned=1, state HALT, imem_req=0 until rst.
REQ-036 rdata=32'h0000007F -> illegal_instr=1, HALT. Then rst=1 for one cycle while in FETCH mid-wait -> flags clear, imem_addr=RESET_PC.

Source files
------------

// File: rtl/InstrTypes.sv
`default_nettype none
// ============================================================================
// InstrTypes : RV32I base opcode constants shared by decode and control.
// Revision   : 1.0
// ============================================================================
package InstrTypes;

   localparam logic [6:0] Rtype      = 7'b0110011;
   localparam logic [6:0] ItypeLd    = 7'b0000011;
   localparam logic [6:0] ItypeImm   = 7'b0010011;
   localparam logic [6:0] ItypeJALR  = 7'b1100111;
   localparam logic [6:0] Stype      = 7'b0100011;
   localparam logic [6:0] Btype      = 7'b1100011;
   localparam logic [6:0] UtypeLUI   = 7'b0110111;
   localparam logic [6:0] UtypeAUIPC = 7'b0010111;
   localparam logic [6:0] Jtype      = 7'b1101111;

endpackage
`default_nettype wire

// File: rtl/Instructions.sv
`default_nettype none
// ============================================================================
// Instructions : next-PC select codes driven by the control unit.
// Revision     : 1.0
// ============================================================================
package Instructions;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_ALU   = 2'd1;
   localparam logic [1:0] PC_IMM   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// imm_gen : combinational RV32I immediate extraction, selected by opcode.
// Revision: 1.0
// ============================================================================
module imm_gen
   import InstrTypes::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'd0;
      case (instr[6:0])
         ItypeLd, ItypeImm, ItypeJALR:
            imm = {{20{instr[31]}}, instr[31:20]};
         Stype:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         Btype:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         UtypeLUI, UtypeAUIPC:
            imm = {instr[31:12], 12'd0};
         Jtype:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// fetch_decode : multi-cycle fetch FSM, instruction register and field decode.
// Revision     : 1.0
// ============================================================================
module fetch_decode
   import InstrTypes::*;
   import Instructions::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  PCSel,
   input  logic [31:0] alu_result,
   input  logic        exec_stall,
   output logic        instr_valid,
   output logic        illegal_instr,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [31:0] c_nop = 32'h0000_0013;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic        r_req;
   logic        r_valid;
   logic        r_illegal;
   logic        r_misaligned;
   logic [31:0] w_imm;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;
   logic        w_legal;

   imm_gen u_imm_gen (
      .instr (r_ir),
      .imm   (w_imm)
   );

   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_next_pc = w_pc_plus4;
      case (PCSel)
         PC_IMM:  w_next_pc = r_pc + w_imm;
         PC_ALU:  w_next_pc = {alu_result[31:1], 1'b0};
         default: w_next_pc = w_pc_plus4;
      endcase
   end

   always_comb begin
      w_legal = 1'b0;
      case (r_ir[6:0])
         Rtype, ItypeLd, ItypeImm, ItypeJALR, Stype,
         Btype, UtypeLUI, UtypeAUIPC, Jtype: w_legal = 1'b1;
         default:                            w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_ir         <= c_nop;
         r_req        <= 1'b1;
         r_valid      <= 1'b0;
         r_illegal    <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ready) begin
                  r_ir    <= imem_rdata;
                  r_state <= EXEC;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            EXEC: begin
               // An illegal opcode halts even while the data side is stalling.
               if (!w_legal) begin
                  r_illegal <= 1'b1;
                  r_state   <= HALT;
                  r_valid   <= 1'b0;
               end else if (!exec_stall) begin
                  r_valid <= 1'b0;
                  if (w_next_pc[1:0] != 2'b00) begin
                     r_misaligned <= 1'b1;
                     r_state      <= HALT;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_state <= FETCH;
                     r_req   <= 1'b1;
                  end
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req      = r_req;
   assign imem_addr     = r_pc;
   assign instr_valid   = r_valid;
   assign illegal_instr = r_illegal;
   assign misaligned    = r_misaligned;
   assign pc            = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign imm           = w_imm;
   assign opcode        = r_ir[6:0];
   assign rd            = r_ir[11:7];
   assign funct3        = r_ir[14:12];
   assign rs1           = r_ir[19:15];
   assign rs2           = r_ir[24:20];
   assign funct7        = r_ir[31:25];

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// tb_fetch_decode : directed self-checking bench for fetch_decode.
// Revision        : 1.0
// ============================================================================
module tb_fetch_decode;
   import Instructions::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm, pc, pc_plus4;
   logic [1:0]  PCSel;
   logic [31:0] alu_result;
   logic        exec_stall;
   logic        instr_valid, illegal_instr, misaligned;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   fetch_decode #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .opcode(opcode),
      .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
      .imm(imm), .pc(pc), .pc_plus4(pc_plus4), .PCSel(PCSel),
      .alu_result(alu_result), .exec_stall(exec_stall),
      .instr_valid(instr_valid), .illegal_instr(illegal_instr),
      .misaligned(misaligned)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Hold imem_ready low for waits cycles, then return the word for one cycle.
   task automatic fetch(input logic [31:0] word, input int waits);
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         @(negedge clk);
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ready = 1'b0;
   endtask

   task automatic exec_step(input logic [1:0] sel, input logic [31:0] alu);
      PCSel      = sel;
      alu_result = alu;
      exec_stall = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
      PCSel = PC_PLUS4; alu_result = 32'd0; exec_stall = 1'b0;
      @(negedge clk);
      do_reset();
      check("rst_req",   {31'd0, imem_req}, 32'd1);
      check("rst_addr",  imem_addr, 32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_flags", {30'd0, illegal_instr, misaligned}, 32'd0);
      check("rst_nop",   {25'd0, opcode}, 32'h13);

      // addi x1,x0,5 after three wait cycles
      fetch(32'h0050_0093, 3);
      check("addi_valid", {31'd0, instr_valid}, 32'd1);
      check("addi_req",   {31'd0, imem_req}, 32'd0);
      check("addi_op",    {25'd0, opcode}, 32'h13);
      check("addi_rd",    {27'd0, rd}, 32'd1);
      check("addi_imm",   imm, 32'd5);
      check("addi_pc4",   pc_plus4, 32'h4);
      exec_step(2'd3, 32'd0);
      check("sel3_addr",  imem_addr, 32'h4);
      check("sel3_req",   {31'd0, imem_req}, 32'd1);

      // jal x0,+0xFC to reach 0x100
      fetch(32'h0FC0_006F, 0);
      check("jal_imm", imm, 32'h0000_00FC);
      exec_step(PC_IMM, 32'd0);
      check("jal_addr", imem_addr, 32'h100);

      // beq with offset -4
      fetch(32'hFE00_0EE3, 1);
      check("beq_imm", imm, 32'hFFFF_FFFC);
      exec_step(PC_IMM, 32'd0);
      check("beq_addr", imem_addr, 32'hFC);

      // stall for four cycles
      fetch(32'h0050_0093, 0);
      PCSel = PC_PLUS4;
      exec_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_pc",    pc, 32'hFC);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_rd",    {27'd0, rd}, 32'd1);
         check("stall_req",   {31'd0, imem_req}, 32'd0);
      end
      exec_stall = 1'b0;
      @(negedge clk);
      check("unstall_req",   {31'd0, imem_req}, 32'd1);
      check("unstall_addr",  imem_addr, 32'h100);
      check("unstall_valid", {31'd0, instr_valid}, 32'd0);

      // jalr to an odd target lands on 0x202 which is misaligned
      fetch(32'h0000_8067, 1);
      check("jalr_op",  {25'd0, opcode}, 32'h67);
      check("jalr_rs1", {27'd0, rs1}, 32'd1);
      exec_step(PC_ALU, 32'h203);
      for (int i = 0; i < 3; i++) begin
         check("mis_flag",  {31'd0, misaligned}, 32'd1);
         check("mis_req",   {31'd0, imem_req}, 32'd0);
         check("mis_valid", {31'd0, instr_valid}, 32'd0);
         check("mis_pc",    pc, 32'h100);
         @(negedge clk);
      end
      do_reset();
      check("rst2_mis",  {31'd0, misaligned}, 32'd0);
      check("rst2_addr", imem_addr, 32'h0);

      // illegal opcode halts even when exec_stall is high
      fetch(32'h0000_007F, 0);
      check("ill_pre", {31'd0, illegal_instr}, 32'd0);
      exec_stall = 1'b1;
      @(negedge clk);
      exec_stall = 1'b0;
      check("ill_flag", {31'd0, illegal_instr}, 32'd1);
      check("ill_req",  {31'd0, imem_req}, 32'd0);
      check("ill_pc",   pc, 32'h0);
      imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
      @(negedge clk);
      imem_ready = 1'b0;
      check("halt_ir",   {25'd0, opcode}, 32'h7F);
      check("halt_flag", {31'd0, illegal_instr}, 32'd1);
      do_reset();
      check("rst3_ill", {31'd0, illegal_instr}, 32'd0);

      // reset asserted while a fetch is waiting
      fetch(32'h0050_0093, 0);
      exec_step(PC_PLUS4, 32'd0);
      check("pre_addr", imem_addr, 32'h4);
      imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      do_reset();
      check("midrst_addr",  imem_addr, 32'h0);
      check("midrst_req",   {31'd0, imem_req}, 32'd1);
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      check("midrst_nop",   {25'd0, opcode}, 32'h13);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
